dmem_responder: RTL

//  Data-memory responder for the MIPS core's load/store port: the memory side of the CPU's request/response handshake.

---
 rtl/mips_mem_pkg.sv | 33 +++
 rtl/dmem_array.sv | 32 +++
 rtl/dmem_responder.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS data-memory responder.
// Holds the responder state encoding and the store byte-enable legality check.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int DMEM_WORD_W = 32;
  localparam int DMEM_BE_W   = 4;
  localparam int DMEM_LAT_W  = 4;

  // An empty mask is a legal no-op store; otherwise the mask must be a naturally aligned
  // word, halfword or byte at the given offset.
  function automatic logic dmem_be_legal(input logic [1:0] off, input logic [DMEM_BE_W-1:0] be);
    logic ok;
    case (be)
      4'b0000: ok = 1'b1;
      4'b1111: ok = (off == 2'd0);
      4'b0011: ok = (off == 2'd0);
      4'b1100: ok = (off == 2'd2);
      4'b0001: ok = (off == 2'd0);
      4'b0010: ok = (off == 2'd1);
      4'b0100: ok = (off == 2'd2);
      4'b1000: ok = (off == 2'd3);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised single-port data RAM with per-byte write enables and a registered read.
// Contents are not reset.
module dmem_array
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   en,
  input  logic                   we,
  input  logic [DMEM_BE_W-1:0]   be,
  input  logic [IDX_W-1:0]       idx,
  input  logic [DMEM_WORD_W-1:0] wdata,
  output logic [DMEM_WORD_W-1:0] rdata
);

  logic [DMEM_WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < DMEM_BE_W; b++) begin
          if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory side of the MIPS core's load/store handshake: one outstanding request, fixed wait states.
// Optional access-error trapping is built in with MIPS_DMEM_TRAP_EN.
//
//   state | meaning
//   IDLE  | req_ready high, waiting for a request
//   WAIT  | request latched, counting down wait states
//   RESP  | rsp_valid high, holding response until rsp_ready
module dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DMEM_BE_W-1:0]   req_be,
  input  logic [DMEM_WORD_W-1:0] req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DMEM_WORD_W-1:0] rsp_rdata,
  output logic                   rsp_err
);

  localparam int IDX_W = $clog2(DEPTH);

  dmem_state_t state, state_nxt;
  logic [DMEM_LAT_W-1:0] cnt, cnt_nxt;

  logic                   lat_we;
  logic [ADDR_W-1:0]      lat_addr;
  logic [DMEM_BE_W-1:0]   lat_be;
  logic [DMEM_WORD_W-1:0] lat_wdata;
  logic                   err_q;

  logic                   accept;
  logic                   enter_resp;
  logic                   acc_we;
  logic [ADDR_W-1:0]      acc_addr;
  logic [DMEM_BE_W-1:0]   acc_be;
  logic [DMEM_WORD_W-1:0] acc_wdata;
  logic                   acc_err;
  logic [DMEM_WORD_W-1:0] arr_rdata;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = DMEM_LAT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_be    <= '0;
      lat_wdata <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_be    <= req_be;
        lat_wdata <= req_wdata;
      end
      if (enter_resp) err_q <= acc_err;
    end
  end

  // With zero wait states the array is accessed on the acceptance edge, so use the live request.
  assign acc_we    = (state == IDLE) ? req_we    : lat_we;
  assign acc_addr  = (state == IDLE) ? req_addr  : lat_addr;
  assign acc_be    = (state == IDLE) ? req_be    : lat_be;
  assign acc_wdata = (state == IDLE) ? req_wdata : lat_wdata;

`ifdef MIPS_DMEM_TRAP_EN
  assign acc_err = (acc_we ? !dmem_be_legal(acc_addr[1:0], acc_be) : (acc_addr[1:0] != 2'b00))
                 || (acc_addr[ADDR_W-1:IDX_W+2] != '0);
`else
  assign acc_err = 1'b0;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{acc_addr[1:0], acc_addr[ADDR_W-1:IDX_W+2]};
`endif

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .en    (enter_resp && !acc_err),
    .we    (acc_we),
    .be    (acc_be),
    .idx   (acc_addr[IDX_W+1:2]),
    .wdata (acc_wdata),
    .rdata (arr_rdata)
  );

  assign rsp_err   = (state == RESP) && err_q;
  assign rsp_rdata = (state == RESP && !lat_we && !err_q) ? arr_rdata : '0;

endmodule
